uart_tx_sched: RTL

Two-requester UART transmit scheduler for the oscilloscope link. It arbitrates byte requests from two sources (for example the sample-frame streamer and the command/status responder) with round-robin priority. It owns the `bps_start` enable of the shared baud-tick generator and serialises each granted byte as an 8N1 frame (optionally 8N2) on `rs232_tx`, advancing one bit per `clk_bps` tick.

---
 rtl/uart_tx_sched.sv | 97 +++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin UART transmit scheduler.
// Owns the baud generator enable and serialises each granted byte as 8N1/8N2.
module uart_tx_sched #(
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  input  logic       clk_bps,
  output logic       bps_start,
  output logic       rs232_tx,
  output logic       busy,
  output logic       grant
);

  localparam int unsigned TW       = 4;
  localparam int unsigned END_TICK = 10 + STOP_BITS;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state;
  logic [TW-1:0]   tcnt;
  logic [7:0]      shreg;
  logic            last;
  logic [TW-1:0]   tcnt_nxt_c;
  logic            hit_c;
  logic            sel_c;

  // Requester 1 wins when it is alone, or when both ask and 0 went last.
  always_comb begin
    hit_c      = req0 | req1;
    sel_c      = req1 & (~req0 | ~last);
    tcnt_nxt_c = tcnt + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tcnt      <= '0;
      shreg     <= '0;
      last      <= 1'b1;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      bps_start <= 1'b0;
      rs232_tx  <= 1'b1;
      busy      <= 1'b0;
      grant     <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          bps_start <= 1'b0;
          busy      <= 1'b0;
          rs232_tx  <= 1'b1;
          if (hit_c) begin
            shreg     <= sel_c ? data1 : data0;
            ack0      <= ~sel_c;
            ack1      <= sel_c;
            grant     <= sel_c;
            last      <= sel_c;
            tcnt      <= '0;
            bps_start <= 1'b1;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (clk_bps) begin
            tcnt <= tcnt_nxt_c;
            if (tcnt_nxt_c == TW'(1)) begin
              rs232_tx <= 1'b0;
            end else if (tcnt_nxt_c <= TW'(9)) begin
              // Data bits go out LSB first from the bottom of the shifter.
              rs232_tx <= shreg[0];
              shreg    <= {1'b0, shreg[7:1]};
            end else if (tcnt_nxt_c == TW'(END_TICK)) begin
              rs232_tx  <= 1'b1;
              bps_start <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              rs232_tx <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
